// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between the MEM_WB
// stage and buffered mul/div results. A live pipeline write always wins.
// MDU results queue in a small FIFO and drain through idle write slots.
// The FIFO head has an age counter. The arbiter requests a pipeline stall
// when the FIFO is nearly full or the head has waited too long.
module wb_port_arbiter #(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_we_i,
  input  logic        wb_mem_to_reg_i,
  input  logic [31:0] wb_mem_data_i,
  input  logic [31:0] wb_alu_result_i,
  input  logic [4:0]  wb_reg_i,
  input  logic        mdu_valid_i,
  input  logic [4:0]  mdu_reg_i,
  input  logic [31:0] mdu_data_i,
  output logic        mdu_ready_o,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  output logic [31:0] pending_mask_o,
  output logic        pipe_stall_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int AW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [CW-1:0] STALL_LVL  = CW'(DEPTH - 1);
  localparam logic [AW-1:0] MAX_WAIT_C = AW'(MAX_WAIT);

  logic [4:0]    fifo_reg_q  [DEPTH];
  logic [4:0]    fifo_reg_d  [DEPTH];
  logic [31:0]   fifo_data_q [DEPTH];
  logic [31:0]   fifo_data_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] age_q, age_d;

  logic          wb_live;
  logic          fifo_empty;
  logic          ready;
  logic          pop;
  logic          push;
  logic [31:0]   pending_mask;

  // Slot arbitration: a live pipeline write blocks the MDU pop. A result
  // for r0 is accepted so the MDU can move on, but it is never stored.
  always_comb begin
    wb_live    = wb_we_i && (wb_reg_i != 5'd0);
    fifo_empty = (count_q == '0);
    ready      = (count_q < DEPTH_C);
    pop        = !wb_live && !fifo_empty;
    push       = mdu_valid_i && ready && (mdu_reg_i != 5'd0);
  end

  // Next-state logic for the FIFO, the pointers, the count and the head age.
  always_comb begin
    fifo_reg_d  = fifo_reg_q;
    fifo_data_d = fifo_data_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (push) begin
      fifo_reg_d[wr_ptr_q]  = mdu_reg_i;
      fifo_data_d[wr_ptr_q] = mdu_data_i;
      wr_ptr_d              = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    count_d = count_q + CW'(push) - CW'(pop);
    if (fifo_empty || pop) begin
      age_d = '0;
    end else if (age_q == MAX_WAIT_C) begin
      age_d = age_q;
    end else begin
      age_d = age_q + AW'(1);
    end
  end

  // Scoreboard: decode the destination registers of all occupied FIFO slots.
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ({1'b0, PW'(PW'(i) - rd_ptr_q)} < count_q) begin
        pending_mask[fifo_reg_q[i]] = 1'b1;
      end
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_reg_q[i]  <= '0;
        fifo_data_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      age_q    <= '0;
    end else begin
      fifo_reg_q  <= fifo_reg_d;
      fifo_data_q <= fifo_data_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      age_q       <= age_d;
    end
  end

  // Output mux. Every output is held at zero while reset is asserted,
  // including outputs that are driven straight from the inputs.
  always_comb begin
    mdu_ready_o    = 1'b0;
    rf_we_o        = 1'b0;
    rf_waddr_o     = '0;
    rf_wdata_o     = '0;
    pending_mask_o = '0;
    pipe_stall_o   = 1'b0;
    if (rst) begin
      mdu_ready_o    = ready;
      pending_mask_o = pending_mask;
      pipe_stall_o   = (count_q >= STALL_LVL) || (age_q == MAX_WAIT_C);
      if (wb_live) begin
        rf_we_o    = 1'b1;
        rf_waddr_o = wb_reg_i;
        rf_wdata_o = wb_mem_to_reg_i ? wb_mem_data_i : wb_alu_result_i;
      end else if (!fifo_empty) begin
        rf_we_o    = 1'b1;
        rf_waddr_o = fifo_reg_q[rd_ptr_q];
        rf_wdata_o = fifo_data_q[rd_ptr_q];
      end
    end
  end

  // Decode must hold off any pipeline write to a register with a buffered
  // MDU result. Otherwise the older MDU value would land after the newer
  // pipeline value.
  wb_hazard_a: assert property (@(posedge clk) disable iff (!rst)
    !(wb_live && pending_mask[wb_reg_i]));

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Testbench for wb_port_arbiter. Directed scenarios are followed by a
// randomized run. A queue-based reference model supplies every expected value.
module tb_wb_port_arbiter;

  localparam int DEPTH    = 4;
  localparam int MAX_WAIT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_we, wb_m2r;
  logic [31:0] wb_mem, wb_alu;
  logic [4:0]  wb_reg;
  logic        mdu_valid;
  logic [4:0]  mdu_reg;
  logic [31:0] mdu_data;
  logic        mdu_ready, rf_we, pipe_stall;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, pending_mask;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  ent_t mq[$];
  int   m_age = 0;
  bit   in_reset;

  wb_port_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk             (clk),
    .rst             (rst),
    .wb_we_i         (wb_we),
    .wb_mem_to_reg_i (wb_m2r),
    .wb_mem_data_i   (wb_mem),
    .wb_alu_result_i (wb_alu),
    .wb_reg_i        (wb_reg),
    .mdu_valid_i     (mdu_valid),
    .mdu_reg_i       (mdu_reg),
    .mdu_data_i      (mdu_data),
    .mdu_ready_o     (mdu_ready),
    .rf_we_o         (rf_we),
    .rf_waddr_o      (rf_waddr),
    .rf_wdata_o      (rf_wdata),
    .pending_mask_o  (pending_mask),
    .pipe_stall_o    (pipe_stall)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] m_mask();
    logic [31:0] m = '0;
    foreach (mq[i]) m[mq[i].r] = 1'b1;
    return m;
  endfunction

  // Advance the reference model by one clock, using the inputs driven now.
  task automatic model_step();
    bit live, was_empty, pop, acc;
    ent_t e;
    if (in_reset) return;
    live      = wb_we && (wb_reg != 5'd0);
    was_empty = (mq.size() == 0);
    pop       = !live && !was_empty;
    acc       = mdu_valid && (mq.size() < DEPTH);
    if (was_empty || pop) m_age = 0;
    else if (m_age < MAX_WAIT) m_age++;
    if (pop) void'(mq.pop_front());
    if (acc && mdu_reg != 5'd0) begin
      e.r = mdu_reg;
      e.d = mdu_data;
      mq.push_back(e);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    wb_we = 0; wb_m2r = 0; wb_mem = '0; wb_alu = '0; wb_reg = '0;
    mdu_valid = 0; mdu_reg = '0; mdu_data = '0;
  endtask

  task automatic test_reset();
    rst = 0; in_reset = 1;
    idle_inputs();
    wb_we = 1; wb_reg = 5; wb_alu = 32'h55; mdu_valid = 1; mdu_reg = 3;
    #2;
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL rst0_we: got %b want 0", rf_we); end
    checks++; if (rf_waddr !== 5'd0) begin failures++; $display("FAIL rst0_waddr: got %0d want 0", rf_waddr); end
    checks++; if (rf_wdata !== 32'd0) begin failures++; $display("FAIL rst0_wdata: got %h want 0", rf_wdata); end
    checks++; if (mdu_ready !== 1'b0) begin failures++; $display("FAIL rst0_ready: got %b want 0", mdu_ready); end
    @(negedge clk);
    rst = 1; in_reset = 0; mq.delete(); m_age = 0;
    wb_we = 1; wb_reg = 1; wb_alu = 32'h11;
    for (int k = 2; k <= 4; k++) begin
      mdu_valid = 1; mdu_reg = 5'(k); mdu_data = 32'(k * 256);
      #1; tick();
    end
    mdu_valid = 0;
    #1;
    checks++; if (pending_mask !== 32'h1C) begin failures++; $display("FAIL rst_pre_mask: got %h want %h", pending_mask, 32'h1C); end
    checks++; if (pipe_stall !== 1'b1) begin failures++; $display("FAIL rst_pre_stall: got %b want 1", pipe_stall); end
    rst = 0; in_reset = 1;
    #1;
    checks++; if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin
      failures++; $display("FAIL rst_mid_rf: got we=%b addr=%0d data=%h want all 0", rf_we, rf_waddr, rf_wdata); end
    checks++; if (pending_mask !== 32'd0 || pipe_stall !== 1'b0 || mdu_ready !== 1'b0) begin
      failures++; $display("FAIL rst_mid_ctl: got mask=%h stall=%b ready=%b want all 0", pending_mask, pipe_stall, mdu_ready); end
    mq.delete(); m_age = 0;
    @(posedge clk); @(negedge clk);
    rst = 1; in_reset = 0;
    idle_inputs();
    #1;
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL rst_post_we: got %b want 0", rf_we); end
    checks++; if (pending_mask !== 32'd0) begin failures++; $display("FAIL rst_post_mask: got %h want 0", pending_mask); end
    checks++; if (mdu_ready !== 1'b1 || pipe_stall !== 1'b0) begin
      failures++; $display("FAIL rst_post_ctl: got ready=%b stall=%b want 1/0", mdu_ready, pipe_stall); end
    tick();
  endtask

  task automatic test_pipeline();
    idle_inputs();
    wb_we = 1; wb_reg = 5; wb_m2r = 1; wb_mem = 32'hDEAD_BEEF; wb_alu = 32'h1;
    #1;
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5) begin
      failures++; $display("FAIL pipe_we_addr: got we=%b addr=%0d want 1/5", rf_we, rf_waddr); end
    checks++; if (rf_wdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL pipe_mem: got %h want DEADBEEF", rf_wdata); end
    wb_m2r = 0;
    #1;
    checks++; if (rf_wdata !== 32'h1) begin failures++; $display("FAIL pipe_alu: got %h want 1", rf_wdata); end
    tick();
  endtask

  task automatic test_idle_slot();
    idle_inputs();
    mdu_valid = 1; mdu_reg = 7; mdu_data = 32'h1234;
    #1;
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL idle_nobypass: got %b want 0", rf_we); end
    tick();
    mdu_valid = 0;
    #1;
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h1234) begin
      failures++; $display("FAIL idle_write: got we=%b addr=%0d data=%h want 1/7/1234", rf_we, rf_waddr, rf_wdata); end
    checks++; if (pending_mask[7] !== 1'b1) begin failures++; $display("FAIL idle_mask_set: got %b want 1", pending_mask[7]); end
    tick();
    #1;
    checks++; if (pending_mask[7] !== 1'b0 || rf_we !== 1'b0) begin
      failures++; $display("FAIL idle_mask_clr: got mask7=%b we=%b want 0/0", pending_mask[7], rf_we); end
  endtask

  task automatic test_starvation();
    idle_inputs();
    wb_we = 1; wb_reg = 3; wb_alu = 32'h33;
    mdu_valid = 1; mdu_reg = 9; mdu_data = 32'h99;
    #1; tick();
    mdu_valid = 0;
    for (int i = 0; i < MAX_WAIT; i++) begin
      #1;
      checks++; if (pipe_stall !== 1'b0) begin failures++; $display("FAIL starve_early cyc%0d: got %b want 0", i, pipe_stall); end
      tick();
    end
    #1;
    checks++; if (pipe_stall !== 1'b1) begin failures++; $display("FAIL starve_stall: got %b want 1", pipe_stall); end
    tick(); tick();
    #1;
    checks++; if (pipe_stall !== 1'b1 || rf_waddr !== 5'd3) begin
      failures++; $display("FAIL starve_sat: got stall=%b addr=%0d want 1/3", pipe_stall, rf_waddr); end
    wb_we = 0;
    #1;
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'h99) begin
      failures++; $display("FAIL starve_bubble: got we=%b addr=%0d data=%h want 1/9/99", rf_we, rf_waddr, rf_wdata); end
    tick();
    #1;
    checks++; if (pipe_stall !== 1'b0 || pending_mask !== 32'd0) begin
      failures++; $display("FAIL starve_after: got stall=%b mask=%h want 0/0", pipe_stall, pending_mask); end
  endtask

  task automatic test_full();
    idle_inputs();
    wb_we = 1; wb_reg = 1; wb_alu = 32'hAA;
    for (int k = 0; k < 4; k++) begin
      mdu_valid = 1; mdu_reg = 5'(10 + k); mdu_data = 32'(k + 100);
      #1;
      checks++; if (pipe_stall !== (k >= 3) || mdu_ready !== 1'b1) begin
        failures++; $display("FAIL full_fill cnt%0d: got stall=%b ready=%b want %b/1", k, pipe_stall, mdu_ready, (k >= 3)); end
      tick();
    end
    mdu_reg = 14; mdu_data = 32'hEE;
    #1;
    checks++; if (mdu_ready !== 1'b0 || pipe_stall !== 1'b1) begin
      failures++; $display("FAIL full_ready: got ready=%b stall=%b want 0/1", mdu_ready, pipe_stall); end
    tick();
    wb_we = 0;
    #1;
    checks++; if (mdu_ready !== 1'b0 || rf_waddr !== 5'd10) begin
      failures++; $display("FAIL full_popcyc: got ready=%b addr=%0d want 0/10", mdu_ready, rf_waddr); end
    tick();
    mdu_valid = 0;
    #1;
    checks++; if (mdu_ready !== 1'b1) begin failures++; $display("FAIL full_reopen: got %b want 1", mdu_ready); end
    checks++; if (pending_mask !== 32'h3800) begin failures++; $display("FAIL full_mask: got %h want 3800", pending_mask); end
    for (int k = 1; k < 4; k++) begin
      #1;
      checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'(10 + k) || rf_wdata !== 32'(k + 100)) begin
        failures++; $display("FAIL full_drain%0d: got we=%b addr=%0d data=%h", k, rf_we, rf_waddr, rf_wdata); end
      tick();
    end
    #1;
    checks++; if (rf_we !== 1'b0 || pending_mask !== 32'd0) begin
      failures++; $display("FAIL full_empty: got we=%b mask=%h want 0/0", rf_we, pending_mask); end
  endtask

  task automatic test_r0();
    idle_inputs();
    mdu_valid = 1; mdu_reg = 0; mdu_data = 32'hBAD;
    #1;
    checks++; if (mdu_ready !== 1'b1) begin failures++; $display("FAIL r0_ready: got %b want 1", mdu_ready); end
    tick();
    mdu_valid = 0;
    #1;
    checks++; if (rf_we !== 1'b0 || pending_mask !== 32'd0 || pipe_stall !== 1'b0) begin
      failures++; $display("FAIL r0_discard: got we=%b mask=%h stall=%b want 0/0/0", rf_we, pending_mask, pipe_stall); end
    wb_we = 1; wb_reg = 1; mdu_valid = 1; mdu_reg = 6; mdu_data = 32'h66;
    #1; tick();
    mdu_valid = 0; wb_reg = 0; wb_alu = 32'h77;
    #1;
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd6 || rf_wdata !== 32'h66) begin
      failures++; $display("FAIL r0_wbslot: got we=%b addr=%0d data=%h want 1/6/66", rf_we, rf_waddr, rf_wdata); end
    tick();
    #1;
    checks++; if (rf_we !== 1'b0 || pending_mask !== 32'd0) begin
      failures++; $display("FAIL r0_after: got we=%b mask=%h want 0/0", rf_we, pending_mask); end
  endtask

  task automatic test_random();
    int prob;
    logic [4:0]  r;
    logic [31:0] mk, e_data;
    logic [4:0]  e_addr;
    bit          live, e_we;
    for (int cyc = 0; cyc < 600; cyc++) begin
      case ((cyc / 75) % 4)
        0: prob = 30;
        1: prob = 85;
        2: prob = 97;
        default: prob = 55;
      endcase
      mk = m_mask();
      wb_we  = ($urandom_range(0, 99) < prob);
      wb_m2r = $urandom_range(0, 1);
      wb_mem = $urandom;
      wb_alu = $urandom;
      r = 5'($urandom_range(0, 31));
      if (mk[r]) r = 5'd0;
      wb_reg = r;
      mdu_valid = $urandom_range(0, 1);
      mdu_reg   = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      mdu_data  = $urandom;
      #1;
      live   = wb_we && (wb_reg != 5'd0);
      e_we   = live || (mq.size() > 0);
      e_addr = live ? wb_reg : ((mq.size() > 0) ? mq[0].r : 5'd0);
      e_data = live ? (wb_m2r ? wb_mem : wb_alu) : ((mq.size() > 0) ? mq[0].d : 32'd0);
      checks++; if (rf_we !== e_we) begin failures++; $display("FAIL rnd_we cyc%0d: got %b want %b", cyc, rf_we, e_we); end
      checks++; if (rf_waddr !== e_addr) begin failures++; $display("FAIL rnd_addr cyc%0d: got %0d want %0d", cyc, rf_waddr, e_addr); end
      checks++; if (rf_wdata !== e_data) begin failures++; $display("FAIL rnd_data cyc%0d: got %h want %h", cyc, rf_wdata, e_data); end
      checks++; if (mdu_ready !== (mq.size() < DEPTH)) begin
        failures++; $display("FAIL rnd_ready cyc%0d: got %b want %b", cyc, mdu_ready, (mq.size() < DEPTH)); end
      checks++; if (pipe_stall !== ((mq.size() >= DEPTH - 1) || (m_age == MAX_WAIT))) begin
        failures++; $display("FAIL rnd_stall cyc%0d: got %b want %b", cyc, pipe_stall, ((mq.size() >= DEPTH - 1) || (m_age == MAX_WAIT))); end
      checks++; if (pending_mask !== mk) begin failures++; $display("FAIL rnd_mask cyc%0d: got %h want %h", cyc, pending_mask, mk); end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_pipeline();
    test_idle_slot();
    test_starvation();
    test_full();
    test_r0();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
